status_pcr_unit: RTL and testbench

- Parametrised machine status register block: status word, interrupt-pending/mask logic, count/compare timer.
- Hardware exception entry and return (ERET) update the supervisor and interrupt-enable bits atomically.
- Sits beside the core's PCR file; drives status fields to the pipeline and raises a registered interrupt request.

---
 rtl/status_pcr_unit_if.sv | 10 +
 rtl/status_pcr_unit.sv | 129 ++++++++++++
 tb/tb_status_pcr_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/status_pcr_unit_if.sv
// status_pcr_unit_if: software read/write port of the status PCR block
interface status_pcr_unit_if #(parameter int DATA_W = 32);
  logic              io_wen;
  logic [1:0]        io_waddr;
  logic [DATA_W-1:0] io_wdata;
  logic [1:0]        io_raddr;
  logic [DATA_W-1:0] io_rdata;
  modport master(output io_wen, io_waddr, io_wdata, io_raddr, input io_rdata);
  modport slave(input io_wen, io_waddr, io_wdata, io_raddr, output io_rdata);
endinterface

// File: rtl/status_pcr_unit.sv
// status_pcr_unit: machine status word, interrupt pending/mask and count/compare timer (timer present only with STATUS_PCR_TIMER_EN)
module status_pcr_unit #(
  parameter int IM_W    = 8,
  parameter int DATA_W  = 32,
  parameter int TIMER_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  status_pcr_unit_if.slave bus,
  input  logic            io_exception,
  input  logic            io_eret,
  input  logic [IM_W-1:0] io_irq,
  output logic [IM_W-1:0] io_status_im,
  output logic            io_status_s,
  output logic            io_status_ps,
  output logic            io_status_et,
  output logic            io_status_ef,
  output logic            io_status_ev,
  output logic            io_status_ec,
  output logic            io_status_vm,
  output logic            io_status_s64,
  output logic            io_status_u64,
  output logic            io_irq_req
);
  localparam int ET = 0;
  localparam int PS = 4;
  localparam int S  = 5;
  logic [8:0]        r_st;
  logic [IM_W-1:0]   r_im;
  logic [IM_W-1:0]   r_ip;
  logic              r_irq_req;
  logic              w_st_wr;
  logic              w_clr_wr;
  logic              w_match;
  logic              w_cmp_clr;
  logic [IM_W-1:0]   w_set;
  logic [IM_W-1:0]   w_clr;
  logic [DATA_W-1:0] w_status_word;
  logic [DATA_W-1:0] w_ip_word;
  logic [DATA_W-1:0] w_count_word;
  logic [DATA_W-1:0] w_cmp_word;
  assign w_st_wr  = bus.io_wen && bus.io_waddr == 2'd0;
  assign w_clr_wr = bus.io_wen && bus.io_waddr == 2'd3;
`ifdef STATUS_PCR_TIMER_EN
  logic [TIMER_W-1:0] r_count;
  logic [TIMER_W-1:0] r_compare;
  logic               w_cnt_wr;
  logic               w_cmp_wr;
  assign w_cnt_wr  = bus.io_wen && bus.io_waddr == 2'd1;
  assign w_cmp_wr  = bus.io_wen && bus.io_waddr == 2'd2;
  assign w_match   = r_count == r_compare;
  assign w_cmp_clr = w_cmp_wr;
  // free-running counter with software load; compare holds until rewritten
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_count   <= '0;
      r_compare <= '1;
    end else begin
      r_count <= w_cnt_wr ? bus.io_wdata[TIMER_W-1:0] : r_count + TIMER_W'(1);
      if (w_cmp_wr) r_compare <= bus.io_wdata[TIMER_W-1:0];
    end
  // zero-extend timer registers onto the read bus
  always_comb begin
    w_count_word = '0;
    w_cmp_word   = '0;
    w_count_word[TIMER_W-1:0] = r_count;
    w_cmp_word[TIMER_W-1:0]   = r_compare;
  end
`else
  assign w_match      = 1'b0;
  assign w_cmp_clr    = 1'b0;
  assign w_count_word = '0;
  assign w_cmp_word   = '0;
`endif
  // exception beats eret beats a software status write; the losers are dropped whole
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_st <= 9'h020;
      r_im <= '0;
    end else if (io_exception) begin
      r_st[PS] <= r_st[S];
      r_st[S]  <= 1'b1;
      r_st[ET] <= 1'b0;
    end else if (io_eret) begin
      r_st[S]  <= r_st[PS];
      r_st[ET] <= 1'b1;
    end else if (w_st_wr) begin
      r_st <= bus.io_wdata[8:0];
      r_im <= bus.io_wdata[16 +: IM_W];
    end
  // pending sets/clears; a compare write suppresses the timer match, any set beats a clear
  always_comb begin
    w_set = io_irq;
    w_set[IM_W-1] = io_irq[IM_W-1] | (w_match & ~w_cmp_clr);
    w_clr = w_clr_wr ? bus.io_wdata[IM_W-1:0] : '0;
    w_clr[IM_W-1] = w_clr[IM_W-1] | w_cmp_clr;
  end
  // pending bits and the registered interrupt request from pre-edge state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ip      <= '0;
      r_irq_req <= 1'b0;
    end else begin
      r_ip      <= (r_ip & ~w_clr) | w_set;
      r_irq_req <= r_st[ET] & |(r_ip & r_im);
    end
  // assemble status and pending words with unused bits forced to zero
  always_comb begin
    w_status_word = '0;
    w_status_word[8:0] = r_st;
    w_status_word[16 +: IM_W] = r_im;
    w_ip_word = '0;
    w_ip_word[IM_W-1:0] = r_ip;
  end
  assign bus.io_rdata = bus.io_raddr == 2'd0 ? w_status_word :
                        bus.io_raddr == 2'd1 ? w_count_word :
                        bus.io_raddr == 2'd2 ? w_cmp_word : w_ip_word;
  assign io_status_et  = r_st[0];
  assign io_status_ef  = r_st[1];
  assign io_status_ev  = r_st[2];
  assign io_status_ec  = r_st[3];
  assign io_status_ps  = r_st[4];
  assign io_status_s   = r_st[5];
  assign io_status_u64 = r_st[6];
  assign io_status_s64 = r_st[7];
  assign io_status_vm  = r_st[8];
  assign io_status_im  = r_im;
  assign io_irq_req    = r_irq_req;
endmodule

// File: tb/tb_status_pcr_unit.sv
// tb_status_pcr_unit: scoreboard bench for status_pcr_unit; timer checks follow STATUS_PCR_TIMER_EN
module tb_status_pcr_unit;
  typedef struct {string n; logic [31:0] v;} exp_t;
  logic clk = 0;
  logic reset = 1;
  logic io_exception = 0;
  logic io_eret = 0;
  logic [7:0] io_irq = '0;
  logic [7:0] io_status_im;
  logic io_status_s, io_status_ps, io_status_et, io_status_ef, io_status_ev;
  logic io_status_ec, io_status_vm, io_status_s64, io_status_u64, io_irq_req;
  exp_t exp_q[$];
  exp_t e;
  logic [31:0] obs;
  int checks = 0;
  int failures = 0;
  status_pcr_unit_if #(.DATA_W(32)) bus();
  status_pcr_unit #(.IM_W(8), .DATA_W(32), .TIMER_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .io_exception(io_exception), .io_eret(io_eret), .io_irq(io_irq),
    .io_status_im(io_status_im), .io_status_s(io_status_s), .io_status_ps(io_status_ps),
    .io_status_et(io_status_et), .io_status_ef(io_status_ef), .io_status_ev(io_status_ev),
    .io_status_ec(io_status_ec), .io_status_vm(io_status_vm), .io_status_s64(io_status_s64),
    .io_status_u64(io_status_u64), .io_irq_req(io_irq_req)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.io_raddr = a;
    #1;
    d = bus.io_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.io_wen = 1;
    bus.io_waddr = a;
    bus.io_wdata = d;
    tick();
    bus.io_wen = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    exp_q.push_back('{"reset_s", 32'h1});
    exp_q.push_back('{"reset_et", 32'h0});
    exp_q.push_back('{"reset_im", 32'h0});
    exp_q.push_back('{"reset_irq_req", 32'h0});
    exp_q.push_back('{"reset_status_rd", 32'h20});
    exp_q.push_back('{"reset_ip_rd", 32'h0});
    obs = 32'(io_status_s); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    obs = 32'(io_status_et); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    obs = 32'(io_status_im); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    obs = 32'(io_irq_req); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    rd(2'd0, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    rd(2'd3, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
  endtask

  task automatic test_irq();
    wr(2'd0, 32'h00FF0001);
    exp_q.push_back('{"irq_status_rd", 32'h00FF0001});
    rd(2'd0, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    io_irq = 8'h01;
    exp_q.push_back('{"irq_ip_set", 32'h01});
    exp_q.push_back('{"irq_req_lag", 32'h0});
    exp_q.push_back('{"irq_req_rise", 32'h1});
    tick();
    io_irq = 8'h00;
    rd(2'd3, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    obs = 32'(io_irq_req); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    tick();
    obs = 32'(io_irq_req); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    wr(2'd3, 32'h1);
    exp_q.push_back('{"irq_pending_clear", 32'h0});
    exp_q.push_back('{"irq_req_drop", 32'h0});
    rd(2'd3, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    tick();
    obs = 32'(io_irq_req); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
  endtask

  task automatic test_exception();
    wr(2'd0, 32'h00FF0021);
    io_irq = 8'h01;
    tick();
    io_irq = 8'h00;
    tick();
    exp_q.push_back('{"exc_pre_irq_req", 32'h1});
    obs = 32'(io_irq_req); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    io_exception = 1;
    exp_q.push_back('{"exc_status", 32'h00FF0030});
    exp_q.push_back('{"exc_irq_req_hold", 32'h1});
    exp_q.push_back('{"exc_irq_req_fall", 32'h0});
    tick();
    io_exception = 0;
    rd(2'd0, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    obs = 32'(io_irq_req); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    tick();
    obs = 32'(io_irq_req); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    wr(2'd0, 32'h00FF0010);
    io_eret = 1;
    exp_q.push_back('{"eret_status", 32'h00FF0031});
    exp_q.push_back('{"eret_s_et", 32'h3});
    tick();
    io_eret = 0;
    rd(2'd0, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    obs = {30'b0, io_status_s, io_status_et}; e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    wr(2'd3, 32'hFF);
  endtask

  task automatic test_priority();
    io_exception = 1;
    io_eret = 1;
    exp_q.push_back('{"prio_exc_only", 32'h00FF0030});
    wr(2'd0, 32'h0);
    io_exception = 0;
    io_eret = 0;
    rd(2'd0, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
  endtask

  task automatic test_mask();
    wr(2'd0, 32'hFFFFFFFF);
    exp_q.push_back('{"mask_status_rd", 32'h00FF01FF});
    exp_q.push_back('{"mask_bits_out", 32'h1FF});
    rd(2'd0, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    obs = {23'b0, io_status_vm, io_status_s64, io_status_u64, io_status_s, io_status_ps, io_status_ec, io_status_ev, io_status_ef, io_status_et};
    e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
  endtask

`ifdef STATUS_PCR_TIMER_EN
  task automatic test_timer();
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h5);
    wr(2'd1, 32'h0);
    exp_q.push_back('{"timer_count_load", 32'h0});
    rd(2'd1, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    repeat (5) tick();
    exp_q.push_back('{"timer_count_5", 32'h5});
    exp_q.push_back('{"timer_ip_before", 32'h0});
    exp_q.push_back('{"timer_ip_match", 32'h80});
    rd(2'd1, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    rd(2'd3, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    tick();
    rd(2'd3, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    wr(2'd3, 32'h80);
    wr(2'd1, 32'h3);
    repeat (2) tick();
    exp_q.push_back('{"timer_count_again_5", 32'h5});
    exp_q.push_back('{"timer_cmp_write_wins", 32'h0});
    exp_q.push_back('{"timer_ip_stays", 32'h0});
    rd(2'd1, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    wr(2'd2, 32'h5);
    rd(2'd3, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    tick();
    rd(2'd3, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
  endtask
`else
  task automatic test_no_timer();
    wr(2'd1, 32'h1234);
    wr(2'd2, 32'h5678);
    exp_q.push_back('{"notimer_count_rd", 32'h0});
    exp_q.push_back('{"notimer_cmp_rd", 32'h0});
    rd(2'd1, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    rd(2'd2, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    io_irq = 8'h80;
    exp_q.push_back('{"notimer_ip7_irq", 32'h80});
    tick();
    io_irq = 8'h00;
    rd(2'd3, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    wr(2'd3, 32'h80);
  endtask
`endif

  task automatic test_reset_mid();
    io_irq = 8'h01;
    tick();
    io_irq = 8'h00;
    tick();
    exp_q.push_back('{"mid_pre_irq_req", 32'h1});
    obs = 32'(io_irq_req); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    reset = 1;
    exp_q.push_back('{"mid_irq_req", 32'h0});
    exp_q.push_back('{"mid_status", 32'h20});
    exp_q.push_back('{"mid_count", 32'h0});
    exp_q.push_back('{"mid_ip", 32'h0});
`ifdef STATUS_PCR_TIMER_EN
    exp_q.push_back('{"mid_compare", 32'hFFFFFFFF});
`endif
    #1;
    obs = 32'(io_irq_req); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    rd(2'd0, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    rd(2'd1, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
    rd(2'd3, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
`ifdef STATUS_PCR_TIMER_EN
    rd(2'd2, obs); e = exp_q.pop_front(); checks++; if (obs !== e.v) begin failures++; $display("FAIL %s observed=%h expected=%h", e.n, obs, e.v); end
`endif
    tick();
    reset = 0;
  endtask

  initial begin
    bus.io_wen = 0;
    bus.io_waddr = '0;
    bus.io_wdata = '0;
    bus.io_raddr = '0;
    test_reset();
    test_irq();
    test_exception();
    test_priority();
    test_mask();
`ifdef STATUS_PCR_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
